// File: rtl/ysyx_25040109_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings, FSM states, op decode helpers.
// No timing of its own.
// No flow control of its own.
package ysyx_25040109_mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // Remainder ops (REM/REMU) select the remainder instead of the quotient
    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic is_signed_src1(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_src2(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // MULH/MULHSU/MULHU return the upper half of the product
    function automatic logic is_high(input logic [2:0] f3);
        return !f3[2] && (f3[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_25040109_mdu_div_core.sv
// Restoring radix-2 divider datapath on unsigned magnitudes; one quotient bit per step.
// Latency: XLEN step cycles after start.
// No backpressure: the controlling FSM decides when to start and step.
module ysyx_25040109_mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Partial remainder is always below the divisor, so the shifted value fits XLEN+1 bits
    // and the top bit of the difference is the borrow.
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvs_q};
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // Load operands on start, otherwise shift in one quotient bit per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ysyx_25040109_mdu.sv
// Multi-cycle RV32M multiply/divide unit with rd tag passthrough and flush; MDU_FAST_MUL_EN selects a single-cycle multiplier.
// Latency: XLEN+1 edges incl. accept for iterative mul/div, 1 edge for div-by-zero, overflow and fast mul.
// Result held on out_valid until out_ready; in_ready low whenever an op is in flight or pending.
module ysyx_25040109_mdu
    import ysyx_25040109_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q;      // quotient / product must be negated
    logic              neg_r;      // remainder must be negated (dividend was negative)
    logic              direct_q;   // result was produced at accept time
    logic [XLEN-1:0]   direct_res;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;

    logic              accept;
    logic              s1_neg;
    logic              s2_neg;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              div_zero;
    logic              div_ovf;
    logic              mul_direct;
    logic              direct_in;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN-1:0]   direct_val;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    // Flush wins over a same-cycle accept
    assign accept = in_valid && in_ready && !flush;

    // Operand signs and magnitudes; MIN maps onto itself, which is the right unsigned magnitude
    assign s1_neg   = is_signed_src1(in_funct3) && in_src1[XLEN-1];
    assign s2_neg   = is_signed_src2(in_funct3) && in_src2[XLEN-1];
    assign mag1     = s1_neg ? (XLEN'(0) - in_src1) : in_src1;
    assign mag2     = s2_neg ? (XLEN'(0) - in_src2) : in_src2;
    assign div_zero = is_div(in_funct3) && (in_src2 == '0);
    assign div_ovf  = is_div(in_funct3) && is_signed_src1(in_funct3) &&
                      (in_src1 == INT_MIN) && (in_src2 == '1);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag;
    logic [2*XLEN-1:0] fast_prod;
    assign fast_mag   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    assign fast_prod  = (s1_neg ^ s2_neg) ? ((2*XLEN)'(0) - fast_mag) : fast_mag;
    assign fast_res   = is_high(in_funct3) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
    assign mul_direct = 1'b1;
`else
    assign fast_res   = '0;
    assign mul_direct = 1'b0;
`endif

    assign direct_in = div_zero || div_ovf || (!is_div(in_funct3) && mul_direct);

    // Result for ops that skip the iterative datapath
    always_comb begin
        direct_val = fast_res;
        if (div_zero) begin
            direct_val = is_rem(in_funct3) ? in_src1 : '1;
        end else if (div_ovf) begin
            direct_val = is_rem(in_funct3) ? '0 : INT_MIN;
        end
    end

    // One shift-add step: add multiplicand to the upper half when the low bit is set, then shift right
    assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {mul_sum, prod[XLEN-1:1]};

    ysyx_25040109_mdu_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_div(in_funct3) && !direct_in),
        .step      (state == DIV),
        .dividend  (mag1),
        .divisor   (mag2),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        out_valid = (state == DONE);
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (direct_in) begin
                        state_nxt = DONE;
                    end else if (is_div(in_funct3)) begin
                        state_nxt = DIV;
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Operand capture on accept, iteration counter and multiplier shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            op         <= '0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            direct_q   <= 1'b0;
            direct_res <= '0;
            mcand      <= '0;
            prod       <= '0;
        end else if (accept) begin
            cnt        <= '0;
            op         <= in_funct3;
            tag_q      <= in_tag;
            neg_q      <= s1_neg ^ s2_neg;
            neg_r      <= s1_neg;
            direct_q   <= direct_in;
            direct_res <= direct_val;
            mcand      <= mag1;
            prod       <= {{XLEN{1'b0}}, mag2};
        end else if (state == MUL || state == DIV) begin
            cnt <= cnt + CNT_W'(1);
            if (state == MUL) begin
                prod <= prod_step;
            end
        end
    end

    // Sign fix-up and result selection; all inputs are registers, so the value holds under backpressure
    assign prod_fix = neg_q ? ((2*XLEN)'(0) - prod) : prod;
    assign quo_fix  = neg_q ? (XLEN'(0) - div_quo) : div_quo;
    assign rem_fix  = neg_r ? (XLEN'(0) - div_rem) : div_rem;

    always_comb begin
        final_res = prod_fix[XLEN-1:0];
        if (direct_q) begin
            final_res = direct_res;
        end else if (is_div(op)) begin
            final_res = is_rem(op) ? rem_fix : quo_fix;
        end else if (is_high(op)) begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    assign out_result = out_valid ? final_res : '0;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_ysyx_25040109_mdu.sv
module tb_ysyx_25040109_mdu;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef MDU_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = XLEN + 1;
`endif
    localparam int DL = XLEN + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_funct3 = '0;
    logic [XLEN-1:0]  in_src1 = '0;
    logic [XLEN-1:0]  in_src2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_25040109_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge with out_ready=1; issues one op and checks it end to end.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int lat);
        int edges;
        chk({name, " in_ready before"}, {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_src1   = a;
        in_src2   = b;
        in_tag    = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        if (lat > 1) begin
            chk({name, " busy in flight"}, {30'b0, busy, in_ready}, 32'd2);
        end
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, " latency"}, 32'(edges), 32'(lat));
        chk({name, " result"}, out_result, exp);
        chk({name, " tag"}, {27'b0, out_tag}, {27'b0, tag});
        @(posedge clk);
        #1;
        chk({name, " idle after"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int vcnt;
        logic [31:0] held_res;
        logic [4:0]  held_tag;

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, ML};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, ML};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, ML};
        vecs[4]  = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, ML};
        vecs[5]  = '{3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, ML};
        vecs[6]  = '{3'b011, 32'h80000000, 32'd2,        32'h00000001, ML};
        vecs[7]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DL};
        vecs[8]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DL};
        vecs[9]  = '{3'b101, 32'd100,      32'd7,        32'd14,       DL};
        vecs[10] = '{3'b111, 32'd100,      32'd7,        32'd2,        DL};
        vecs[11] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DL};
        vecs[12] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DL};
        vecs[13] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DL};
        vecs[14] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[15] = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
        vecs[16] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[17] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

        // Reset values while reset is asserted
        #3;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_result", out_result, 32'd0);
        chk("reset out_tag", {27'b0, out_tag}, 32'd0);
        chk("reset busy/in_ready", {30'b0, busy, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1),
                   vecs[i].exp, vecs[i].lat);
        end

        // Backpressure: result and tag hold, no new accept while pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_funct3 = 3'b101;
        in_src1   = 32'd100;
        in_src2   = 32'd7;
        in_tag    = 5'd9;
        @(posedge clk);
        #1;
        in_funct3 = 3'b000;
        in_src1   = 32'd3;
        in_src2   = 32'd3;
        in_tag    = 5'd30;
        vcnt = 1;
        while (!out_valid && vcnt < 100) begin
            @(posedge clk);
            #1;
            vcnt++;
        end
        chk("bp latency", 32'(vcnt), 32'(DL));
        held_res = out_result;
        held_tag = out_tag;
        chk("bp result", held_res, 32'd14);
        chk("bp tag", {27'b0, held_tag}, 32'd9);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d", k),
                {out_result[29:0], out_valid, in_ready}, {held_res[29:0], 1'b1, 1'b0});
            chk($sformatf("bp tag%0d", k), {27'b0, out_tag}, {27'b0, held_tag});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release idle", {30'b0, out_valid, in_ready}, 32'd1);

        // Flush at iteration 10 of a DIV
        in_valid  = 1'b1;
        in_funct3 = 3'b100;
        in_src1   = 32'd1000;
        in_src2   = 32'd3;
        in_tag    = 5'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush idle", {29'b0, busy, out_valid, in_ready}, 32'd1);
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) vcnt++;
        end
        chk("flush no result", 32'(vcnt), 32'd0);
        run_op("post-flush mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFE, ML);

        // Flush beats a same-cycle accept
        in_valid  = 1'b1;
        flush     = 1'b1;
        in_funct3 = 3'b101;
        in_src1   = 32'd9;
        in_src2   = 32'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush vs accept", {29'b0, busy, out_valid, in_ready}, 32'd1);

        // Asynchronous reset mid-operation
        in_valid  = 1'b1;
        in_funct3 = 3'b101;
        in_src1   = 32'd100;
        in_src2   = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst", {29'b0, busy, out_valid, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) vcnt++;
        end
        chk("rst no result", 32'(vcnt), 32'd0);
        run_op("post-rst remu", 3'b111, 32'd100, 32'd7, 5'd21, 32'd2, DL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
